// File: rtl/crop_norm_pkg.sv
// Shared types and helpers for the crop + normalise stage.
package crop_norm_pkg;

    typedef enum logic [1:0] {
        NORM_BYPASS = 2'd0,
        NORM_MAX    = 2'd1,
        NORM_MINMAX = 2'd2,
        NORM_RSVD   = 2'd3
    } norm_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_NORM,
        S_DONE
    } state_e;

    // Per-pixel sequencing inside S_NORM.
    typedef enum logic [1:0] {
        PH_READ,
        PH_CALC,
        PH_DIV,
        PH_OUT
    } phase_e;

    function automatic int div_cycles(input int pix_w, input int out_w);
        return pix_w + out_w;
    endfunction

endpackage

// File: rtl/crop_norm_mm_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, N_W cycles per divide.
module norm_divider #(
    parameter int N_W = 16,
    parameter int D_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] q
);
    localparam int CNT_W = $clog2(N_W + 1);

    logic [N_W-1:0]   quo;
    logic [D_W-1:0]   rem;
    logic [D_W-1:0]   dreg;
    logic [CNT_W-1:0] cnt;
    logic [D_W:0]     trial;
    logic [D_W-1:0]   sub;
    logic             fit;

    // done/q are combinational on the final step so the caller can register the result that same edge.
    always_comb begin
        trial = {rem, quo[N_W-1]};
        fit   = trial >= {1'b0, dreg};
        sub   = trial[D_W-1:0] - dreg;
        done  = busy && (cnt == CNT_W'(N_W - 1));
        q     = {quo[N_W-2:0], fit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dreg <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            cnt  <= '0;
            quo  <= n;
            rem  <= '0;
            dreg <= d;
        end else if (busy) begin
            quo <= {quo[N_W-2:0], fit};
            rem <= fit ? sub : trial[D_W-1:0];
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/crop_norm_mm.sv
// Crop an OUT_ROWS x OUT_COLS window from a raster frame, then stream it out
// raw, max-normalised or min-max-normalised.
module crop_norm_mm
    import crop_norm_pkg::*;
#(
    parameter int IN_ROWS  = 20,
    parameter int IN_COLS  = 20,
    parameter int OUT_ROWS = 10,
    parameter int OUT_COLS = 10,
    parameter int PIX_W    = 8,
    parameter int OUT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [1:0]                 norm_mode,
    input  logic [$clog2(IN_COLS)-1:0] crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIX_W-1:0]           s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [OUT_W-1:0]           m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       frame_err
);
    localparam int CW   = $clog2(IN_COLS);
    localparam int RW   = $clog2(IN_ROWS);
    localparam int NPIX = OUT_ROWS * OUT_COLS;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int NW   = div_cycles(PIX_W, OUT_W);

    localparam logic [CW-1:0]    X_MAX   = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0]    Y_MAX   = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;
    localparam logic [AW-1:0]    LAST_IX = AW'(NPIX - 1);

    if (OUT_W < PIX_W) begin : g_width_check
        $error("crop_norm_mm: OUT_W must be >= PIX_W");
    end

    state_e           state;
    phase_e           phase;
    norm_mode_e       mode;
    logic [CW-1:0]    x0, col;
    logic [RW-1:0]    y0, row;
    logic [CW:0]      col_rel;
    logic [RW:0]      row_rel;
    logic [PIX_W-1:0] pmin, pmax, rd_q, lo, diff, den;
    logic [PIX_W-1:0] mem [NPIX];
    logic [AW-1:0]    oidx, waddr, ram_addr;
    logic             s_hs, last_beat, in_win, ram_we;
    logic             div_start, div_busy, div_done;
    logic [NW-1:0]    num, div_q;
    logic [OUT_W-1:0] byp, sat;

    always_comb begin
        s_hs      = s_axis_tvalid && s_axis_tready;
        last_beat = (row == RW'(IN_ROWS - 1)) && (col == CW'(IN_COLS - 1));
        col_rel   = {1'b0, col} - {1'b0, x0};
        row_rel   = {1'b0, row} - {1'b0, y0};
        in_win    = (col >= x0) && (row >= y0) &&
                    (col_rel < (CW+1)'(OUT_COLS)) && (row_rel < (RW+1)'(OUT_ROWS));
        waddr     = AW'(int'(row_rel) * OUT_COLS + int'(col_rel));
        ram_we    = (state == S_CAPTURE) && s_hs && in_win;

        // The next pixel's read is launched on the handshake edge, keeping bypass at 2 cycles/pixel.
        if (state == S_CAPTURE)
            ram_addr = waddr;
        else if (phase == PH_OUT && m_axis_tready && oidx != LAST_IX)
            ram_addr = oidx + 1'b1;
        else
            ram_addr = oidx;

        lo        = (mode == NORM_MINMAX) ? pmin : '0;
        diff      = rd_q - lo;
        den       = pmax - lo;
        num       = (NW'(diff) << OUT_W) - NW'(diff);
        div_start = (state == S_NORM) && (phase == PH_CALC) && (mode != NORM_BYPASS) &&
                    (den != '0) && !div_busy;
        byp       = OUT_W'(rd_q) << (OUT_W - PIX_W);
        sat       = (div_q > NW'(OUT_MAX)) ? OUT_MAX : div_q[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= s_axis_tdata;
        rd_q <= mem[ram_addr];
    end

    norm_divider #(
        .N_W (NW),
        .D_W (PIX_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .n     (num),
        .d     (den),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            phase         <= PH_READ;
            mode          <= NORM_BYPASS;
            x0            <= '0;
            y0            <= '0;
            col           <= '0;
            row           <= '0;
            pmin          <= '0;
            pmax          <= '0;
            oidx          <= '0;
            ap_ready      <= 1'b1;
            ap_done       <= 1'b0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state         <= S_CAPTURE;
                        mode          <= (norm_mode == 2'd3) ? NORM_MAX : norm_mode_e'(norm_mode);
                        x0            <= (crop_x0 > X_MAX) ? X_MAX : crop_x0;
                        y0            <= (crop_y0 > Y_MAX) ? Y_MAX : crop_y0;
                        col           <= '0;
                        row           <= '0;
                        pmin          <= '1;
                        pmax          <= '0;
                        frame_err     <= 1'b0;
                        ap_ready      <= 1'b0;
                        s_axis_tready <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (s_hs) begin
                        if (s_axis_tlast != last_beat) frame_err <= 1'b1;
                        if (in_win) begin
                            if (s_axis_tdata < pmin) pmin <= s_axis_tdata;
                            if (s_axis_tdata > pmax) pmax <= s_axis_tdata;
                        end
                        if (col == CW'(IN_COLS - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_beat) begin
                            state         <= S_NORM;
                            phase         <= PH_READ;
                            oidx          <= '0;
                            row           <= '0;
                            s_axis_tready <= 1'b0;
                        end
                    end
                end
                S_NORM: begin
                    case (phase)
                        PH_READ: phase <= PH_CALC;
                        PH_CALC: begin
                            if (div_start) begin
                                phase <= PH_DIV;
                            end else begin
                                m_axis_tdata  <= (mode == NORM_BYPASS) ? byp : '0;
                                m_axis_tvalid <= 1'b1;
                                m_axis_tlast  <= (oidx == LAST_IX);
                                phase         <= PH_OUT;
                            end
                        end
                        PH_DIV: begin
                            if (div_done) begin
                                m_axis_tdata  <= sat;
                                m_axis_tvalid <= 1'b1;
                                m_axis_tlast  <= (oidx == LAST_IX);
                                phase         <= PH_OUT;
                            end
                        end
                        PH_OUT: begin
                            if (m_axis_tready) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                if (oidx == LAST_IX) begin
                                    state   <= S_DONE;
                                    ap_done <= 1'b1;
                                end else begin
                                    oidx  <= oidx + 1'b1;
                                    phase <= PH_CALC;
                                end
                            end
                        end
                        default: phase <= PH_READ;
                    endcase
                end
                S_DONE: begin
                    ap_done  <= 1'b0;
                    ap_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crop_norm_mm.sv
// Directed bench for crop_norm_mm (8x8 in, 2x2 out): reference model plus literal expectations.
module tb_crop_norm_mm;

    typedef int unsigned frame_t [64];
    typedef int unsigned win_t [4];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ap_start = 1'b0;
    logic       ap_ready, ap_done;
    logic [1:0] norm_mode = '0;
    logic [2:0] crop_x0 = '0;
    logic [2:0] crop_y0 = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] s_tdata = '0;
    logic       s_tlast = 1'b0;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic [7:0] m_tdata;
    logic       m_tlast;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_cyc = -10;
    int rdy_mode = 0;
    int unsigned exp_q[$];
    int unsigned got_q[$];
    int hs_q[$];
    bit prev_stall = 0;
    bit prev_done  = 0;
    logic [7:0] prev_data = '0;

    crop_norm_mm #(
        .IN_ROWS  (8),
        .IN_COLS  (8),
        .OUT_ROWS (2),
        .OUT_COLS (2),
        .PIX_W    (8),
        .OUT_W    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .norm_mode     (norm_mode),
        .crop_x0       (crop_x0),
        .crop_y0       (crop_y0),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .frame_err     (frame_err)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endfunction

    // Window extraction and normalisation straight from the arithmetic definition.
    function automatic void model(input frame_t fr, input int mode, input int cx, input int cy,
                                  output win_t ex, output bit flat);
        int x0, y0, m;
        int unsigned w[4];
        int unsigned mn, mx, lo;
        x0 = (cx > 6) ? 6 : cx;
        y0 = (cy > 6) ? 6 : cy;
        mn = 255;
        mx = 0;
        for (int i = 0; i < 4; i++) begin
            w[i] = fr[(y0 + i / 2) * 8 + x0 + i % 2];
            if (w[i] < mn) mn = w[i];
            if (w[i] > mx) mx = w[i];
        end
        m    = (mode == 3) ? 1 : mode;
        lo   = (m == 2) ? mn : 0;
        flat = (m != 0) && (mx == lo);
        for (int i = 0; i < 4; i++) begin
            if (m == 0)    ex[i] = w[i];
            else if (flat) ex[i] = 0;
            else begin
                ex[i] = ((w[i] - lo) * 255) / (mx - lo);
                if (ex[i] > 255) ex[i] = 255;
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 2) != 0);
            default: m_tready = 1'b0;
        endcase
    end

    // Output monitor: every handshake against the model queue, plus stall stability and done timing.
    initial forever begin
        int idx;
        int unsigned e;
        @(negedge clk);
        cyc++;
        if (reset) begin
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", m_tdata, prev_data);
            end
            if (prev_done) chk("done_one_cycle", ap_done, 0);
            if (ap_done) chk("done_after_last", cyc, last_cyc + 1);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    idx = 4 - exp_q.size();
                    e   = exp_q.pop_front();
                    chk("tdata", m_tdata, e);
                    chk("tlast", m_tlast, (idx == 3) ? 1 : 0);
                    got_q.push_back(m_tdata);
                    hs_q.push_back(cyc);
                    if (idx == 3) last_cyc = cyc;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_done  = ap_done;
        end
    end

    task automatic start_frame(input int mode, input int cx, input int cy);
        @(posedge clk);
        #1;
        norm_mode = mode[1:0];
        crop_x0   = cx[2:0];
        crop_y0   = cy[2:0];
        ap_start  = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic feed(input frame_t fr, input int early, output int k);
        int  budget;
        bit  hs;
        k      = 0;
        budget = 0;
        while (k < 64 && budget < 400) begin
            s_tvalid = 1'b1;
            s_tdata  = fr[k][7:0];
            s_tlast  = (early >= 0) ? (k == early) : (k == 63);
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) k++;
            budget++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic make_frame(input int kind, output frame_t fr);
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0:       fr[i] = i;
                1:       fr[i] = 32'h40;
                2:       fr[i] = 0;
                default: fr[i] = $urandom_range(0, 255);
            endcase
        end
    endtask

    task automatic run_frame(input string name, input int mode, input int cx, input int cy,
                             input int kind, input int early, input int rmode, input bit poke,
                             input bit use_lit, input win_t lit);
        frame_t fr;
        win_t   ex;
        bit     flat;
        int     k, n, per;
        make_frame(kind, fr);
        model(fr, mode, cx, cy, ex, flat);
        exp_q.delete();
        got_q.delete();
        hs_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(ex[i]);
        rdy_mode = rmode;
        start_frame(mode, cx, cy);
        feed(fr, early, k);
        chk({name, "/beats_consumed"}, k, 64);
        @(negedge clk);
        chk({name, "/tready_after_capture"}, s_tready, 0);
        if (poke) begin
            @(posedge clk);
            #1;
            norm_mode = 2'd0;
            crop_x0   = 3'd0;
            crop_y0   = 3'd0;
            ap_start  = 1'b1;
            @(posedge clk);
            #1;
            ap_start = 1'b0;
        end
        n = 0;
        while (!ap_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "/done_timeout"}, (n < 4000) ? 1 : 0, 1);
        chk({name, "/beat_count"}, got_q.size(), 4);
        chk({name, "/frame_err"}, frame_err, (early >= 0 && early != 63) ? 1 : 0);
        if (use_lit && got_q.size() == 4)
            for (int i = 0; i < 4; i++) chk({name, "/literal"}, got_q[i], lit[i]);
        if (rmode == 0 && hs_q.size() == 4) begin
            per = (mode == 0 || flat) ? 2 : 18;
            for (int i = 1; i < 4; i++) chk({name, "/beat_interval"}, hs_q[i] - hs_q[i-1], per);
        end
        @(negedge clk);
        chk({name, "/ap_ready_after_done"}, ap_ready, 1);
    endtask

    task automatic reset_in_norm();
        frame_t fr;
        int     k, n, dones;
        make_frame(0, fr);
        exp_q.delete();
        rdy_mode = 2;
        start_frame(1, 2, 3);
        feed(fr, -1, k);
        chk("rst/beats_consumed", k, 64);
        n = 0;
        while (!m_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst/valid_seen", m_tvalid, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst/ap_ready", ap_ready, 1);
        chk("rst/m_tvalid", m_tvalid, 0);
        chk("rst/s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rdy_mode = 0;
        dones    = 0;
        repeat (50) begin
            @(negedge clk);
            if (ap_done) dones++;
        end
        chk("rst/no_done", dones, 0);
        chk("rst/still_idle", ap_ready, 1);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset/ap_ready", ap_ready, 1);
        chk("reset/ap_done", ap_done, 0);
        chk("reset/s_tready", s_tready, 0);
        chk("reset/m_tvalid", m_tvalid, 0);
        chk("reset/m_tdata", m_tdata, 0);
        chk("reset/m_tlast", m_tlast, 0);
        chk("reset/frame_err", frame_err, 0);

        run_frame("max",         1, 2, 3, 0, -1, 0, 0, 1, '{189, 196, 247, 255});
        run_frame("minmax",      2, 2, 3, 0, -1, 0, 0, 1, '{0, 28, 226, 255});
        run_frame("bypass",      0, 2, 3, 0, -1, 0, 0, 1, '{26, 27, 34, 35});
        run_frame("clamp",       0, 7, 7, 0, -1, 0, 0, 1, '{54, 55, 62, 63});
        run_frame("flat_minmax", 2, 1, 1, 1, -1, 0, 0, 1, '{0, 0, 0, 0});
        run_frame("zero_max",    1, 0, 0, 2, -1, 0, 0, 1, '{0, 0, 0, 0});
        run_frame("early_tlast", 0, 2, 3, 0, 10, 0, 0, 1, '{26, 27, 34, 35});
        run_frame("rsvd_mode",   3, 2, 3, 0, -1, 0, 0, 1, '{189, 196, 247, 255});
        run_frame("gaps_minmax", 2, 5, 1, 3, -1, 1, 1, 0, '{0, 0, 0, 0});
        run_frame("gaps_max",    1, 3, 6, 0, -1, 1, 0, 1, '{216, 221, 250, 255});
        reset_in_norm();
        run_frame("after_reset", 0, 4, 4, 0, -1, 0, 0, 1, '{36, 37, 44, 45});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
